prog_sequencer: RTL and testbench

- Run controller that sits directly upstream of the processor top level. It drives the DUT's Reset and Start inputs and consumes its Ack done flag.
- Issues one DUT reset, then runs NUM_PROGS programs back-to-back. Each program gets a Start pulse and a wait for Ack.
- Measures the cycles each program takes and reports each result on a one-cycle valid strobe.
- Aborts the whole run if a program exceeds TIMEOUT cycles.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/phase_timer.sv | 31 +++
 rtl/prog_sequencer.sv | 158 +++++++++++++++
 tb/tb_prog_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default constants for the program run sequencer.
//   seq_state_t : run-controller FSM state encoding
//   Def*        : default parameter values for prog_sequencer
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    START,
    RUN,
    REPORT,
    DONE
  } seq_state_t;

  localparam int unsigned DefNumProgs   = 3;
  localparam int unsigned DefRstCycles  = 2;
  localparam int unsigned DefStartCycles = 2;
  localparam int unsigned DefCw         = 16;
  localparam int unsigned DefTimeout    = 32'h0000_FFFF;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag, used to time fixed-length phases.
//   Clk     : clock, posedge
//   Reset   : synchronous active-high reset, clears the counter
//   Load    : load LoadVal on the next edge (has priority over counting)
//   LoadVal : value to load; a phase of N cycles loads N-1
//   Zero    : counter is zero (last cycle of the phase)
module phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic [W-1:0] LoadVal,
  output logic         Zero
);

  logic [W-1:0] cntQ;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cntQ <= '0;
    end else if (Load) begin
      cntQ <= LoadVal;
    end else if (cntQ != '0) begin
      cntQ <= cntQ - W'(1);
    end
  end

  assign Zero = (cntQ == '0);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller for the processor: resets it once, then runs NUM_PROGS programs
// back-to-back, measuring each program's cycle count and aborting on timeout.
//   Clk, Reset  : clock (posedge) and synchronous active-high reset
//   Go          : start a run (sampled in IDLE and DONE only)
//   DutAck      : done flag from the processor
//   DutReset    : reset to the processor (RST phase)
//   DutStart    : start to the processor (START phase)
//   ProgIdx     : index of the current program
//   Busy        : run in progress
//   Done        : run finished
//   TimedOut    : sticky abort flag, cleared on the next Go
//   CountValid  : one-cycle strobe qualifying CycleCount
//   CycleCount  : measured RUN cycles for ProgIdx
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_PROGS    = DefNumProgs,
  parameter int unsigned RST_CYCLES   = DefRstCycles,
  parameter int unsigned START_CYCLES = DefStartCycles,
  parameter int unsigned CW           = DefCw,
  parameter int unsigned TIMEOUT      = DefTimeout,
  localparam int unsigned PW          = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic          DutAck,
  output logic          DutReset,
  output logic          DutStart,
  output logic [PW-1:0] ProgIdx,
  output logic          Busy,
  output logic          Done,
  output logic          TimedOut,
  output logic          CountValid,
  output logic [CW-1:0] CycleCount
);

  localparam int unsigned MaxPhase = (RST_CYCLES > START_CYCLES) ? RST_CYCLES : START_CYCLES;
  localparam int unsigned TW       = $clog2(MaxPhase + 1);

  seq_state_t    stateQ, stateD;
  logic [PW-1:0] progIdxQ, progIdxD;
  logic          timedOutQ, timedOutD;
  logic [CW-1:0] countQ, countD;
  logic          armedQ, armedD;
  logic          timerLoad;
  logic [TW-1:0] timerVal;
  logic          timerZero;
  logic [CW-1:0] countInc;

  phase_timer #(
    .W (TW)
  ) u_phase_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .Load    (timerLoad),
    .LoadVal (timerVal),
    .Zero    (timerZero)
  );

  assign countInc = countQ + CW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ    <= IDLE;
      progIdxQ  <= '0;
      timedOutQ <= 1'b0;
      countQ    <= '0;
      armedQ    <= 1'b0;
    end else begin
      stateQ    <= stateD;
      progIdxQ  <= progIdxD;
      timedOutQ <= timedOutD;
      countQ    <= countD;
      armedQ    <= armedD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    progIdxD  = progIdxQ;
    timedOutD = timedOutQ;
    countD    = countQ;
    armedD    = armedQ;
    timerLoad = 1'b0;
    timerVal  = '0;
    case (stateQ)
      IDLE, DONE: begin
        if (Go) begin
          stateD    = RST;
          progIdxD  = '0;
          timedOutD = 1'b0;
          countD    = '0;
          timerLoad = 1'b1;
          timerVal  = TW'(RST_CYCLES - 1);
        end
      end
      RST: begin
        if (timerZero) begin
          stateD    = START;
          countD    = '0;
          armedD    = 1'b0;
          timerLoad = 1'b1;
          timerVal  = TW'(START_CYCLES - 1);
        end
      end
      START: begin
        if (timerZero) begin
          stateD = RUN;
        end
      end
      RUN: begin
        // A qualifying Ack wins over a timeout landing in the same cycle.
        if (armedQ && DutAck) begin
          stateD = REPORT;
        end else begin
          // Arm only once Ack has been seen low, so a stale Ack is ignored.
          if (!DutAck) begin
            armedD = 1'b1;
          end
          if (countInc == CW'(TIMEOUT)) begin
            timedOutD = 1'b1;
            countD    = CW'(TIMEOUT);
            stateD    = REPORT;
          end else begin
            countD = countInc;
          end
        end
      end
      REPORT: begin
        if (timedOutQ || (progIdxQ == PW'(NUM_PROGS - 1))) begin
          stateD = DONE;
        end else begin
          stateD    = START;
          progIdxD  = progIdxQ + PW'(1);
          countD    = '0;
          armedD    = 1'b0;
          timerLoad = 1'b1;
          timerVal  = TW'(START_CYCLES - 1);
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  assign DutReset   = (stateQ == RST);
  assign DutStart   = (stateQ == START);
  assign Busy       = (stateQ == RST) || (stateQ == START) || (stateQ == RUN) ||
                      (stateQ == REPORT);
  assign Done       = (stateQ == DONE);
  assign CountValid = (stateQ == REPORT);
  assign TimedOut   = timedOutQ;
  assign ProgIdx    = progIdxQ;
  assign CycleCount = countQ;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer. A per-run expected trace is built from
// the program Ack patterns (stale-high cycles, low cycles, then high) using the
// cycle-count and timeout rules, then compared cycle by cycle against the DUT.
module tb_prog_sequencer;

  localparam int unsigned NP = 3;
  localparam int unsigned RC = 2;
  localparam int unsigned SC = 2;
  localparam int unsigned TO = 10;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Go;
  logic        DutAck;
  logic        DutReset;
  logic        DutStart;
  logic [1:0]  ProgIdx;
  logic        Busy;
  logic        Done;
  logic        TimedOut;
  logic        CountValid;
  logic [15:0] CycleCount;

  int total = 0;
  int bad   = 0;

  int staleA[NP];
  int lowA[NP];

  typedef struct {
    bit rst;
    bit start;
    bit busy;
    bit done;
    bit to;
    bit valid;
    int idx;
    int cnt;
    bit ack;
  } rec_t;

  rec_t trace[$];

  prog_sequencer #(
    .NUM_PROGS    (NP),
    .RST_CYCLES   (RC),
    .START_CYCLES (SC),
    .CW           (16),
    .TIMEOUT      (TO)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Go         (Go),
    .DutAck     (DutAck),
    .DutReset   (DutReset),
    .DutStart   (DutStart),
    .ProgIdx    (ProgIdx),
    .Busy       (Busy),
    .Done       (Done),
    .TimedOut   (TimedOut),
    .CountValid (CountValid),
    .CycleCount (CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(bit rst, bit start, bit busy, bit done, bit to, bit valid,
                              int idx, int cnt, bit ack);
    rec_t r;
    r.rst = rst; r.start = start; r.busy = busy; r.done = done; r.to = to;
    r.valid = valid; r.idx = idx; r.cnt = cnt; r.ack = ack;
    return r;
  endfunction

  // Expected per-cycle behaviour of one run, starting at the first RST cycle.
  task automatic buildTrace();
    int  q;
    int  runLen;
    int  lastIdx;
    bit  acked;
    bit  to;
    trace.delete();
    to = 1'b0;
    lastIdx = 0;
    for (int c = 0; c < RC; c++) trace.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, staleA[0] > 0));
    for (int p = 0; p < NP; p++) begin
      for (int c = 0; c < SC; c++) trace.push_back(mk(0, 1, 1, 0, 0, 0, p, 0, staleA[p] > 0));
      // Ack qualifies on RUN cycle q (1-based) only if it was seen low first.
      q      = staleA[p] + lowA[p] + 1;
      acked  = (lowA[p] > 0) && (q <= TO);
      runLen = acked ? q : TO;
      for (int j = 1; j <= runLen; j++) begin
        trace.push_back(mk(0, 0, 1, 0, 0, 0, p, 0,
                           (j <= staleA[p]) ? 1'b1 : ((j <= staleA[p] + lowA[p]) ? 1'b0 : 1'b1)));
      end
      to = !acked;
      trace.push_back(mk(0, 0, 1, 0, to, 1, p, acked ? q - 1 : TO, 1));
      lastIdx = p;
      if (to) break;
    end
    for (int c = 0; c < 2; c++) trace.push_back(mk(0, 0, 0, 1, to, 0, lastIdx, 0, 0));
  endtask

  task automatic checkZero();
    check("reset_ctl", {DutReset, DutStart, Busy, Done, TimedOut, CountValid}, 0);
    check("reset_idx", ProgIdx, 0);
    check("reset_cnt", CycleCount, 0);
  endtask

  // Runs one Go; abortProg >= 0 asserts Reset on that program's 3rd RUN cycle.
  task automatic runSeq(input bit goNoise, input int abortProg);
    int runSeen;
    rec_t r;
    runSeen = 0;
    buildTrace();
    @(negedge Clk);
    Go     = 1'b1;
    DutAck = trace[0].ack;
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge Clk);
      r  = trace[i];
      Go = (goNoise && r.busy) ? ($urandom_range(0, 2) == 0) : 1'b0;
      check("ctl", {DutReset, DutStart, Busy, Done, TimedOut, CountValid},
            {r.rst, r.start, r.busy, r.done, r.to, r.valid});
      check("idx", ProgIdx, r.idx);
      if (r.valid) check("cnt", CycleCount, r.cnt);
      DutAck = r.ack;
      if (abortProg >= 0 && r.idx == abortProg && r.busy && !r.rst && !r.start && !r.valid) begin
        runSeen++;
        if (runSeen == 3) begin
          Reset = 1'b1;
          Go    = 1'b0;
          @(negedge Clk);
          Reset = 1'b0;
          checkZero();
          @(negedge Clk);
          checkZero();
          return;
        end
      end
    end
  endtask

  initial begin
    Reset  = 1'b1;
    Go     = 1'b0;
    DutAck = 1'b0;
    repeat (3) @(negedge Clk);
    checkZero();
    Reset = 1'b0;
    @(negedge Clk);
    checkZero();

    // Plain run: Ack after 5 low RUN cycles on every program.
    staleA = '{0, 0, 0}; lowA = '{5, 5, 5};
    runSeq(1'b0, -1);

    // Stale Ack held into RUN must not end the program early.
    staleA = '{3, 0, 2}; lowA = '{4, 1, 6};
    runSeq(1'b0, -1);

    // Ack never comes on program 1: timeout, no program 2.
    staleA = '{0, 0, 0}; lowA = '{2, 1000, 3};
    runSeq(1'b0, -1);

    // Go from a timed-out DONE; Ack on the timeout cycle wins, then a real timeout.
    staleA = '{0, 0, 0}; lowA = '{9, 10, 4};
    runSeq(1'b0, -1);

    // Ack high for the whole RUN never arms.
    staleA = '{2, 0, 0}; lowA = '{0, 1, 1};
    runSeq(1'b0, -1);

    // Reset in the middle of program 1, then a clean restart.
    staleA = '{0, 0, 0}; lowA = '{3, 8, 2};
    runSeq(1'b0, 1);
    runSeq(1'b0, -1);

    // Go pulses while busy are ignored.
    staleA = '{1, 0, 0}; lowA = '{5, 3, 4};
    runSeq(1'b1, -1);

    for (int n = 0; n < 20; n++) begin
      for (int p = 0; p < NP; p++) begin
        staleA[p] = $urandom_range(0, 3);
        lowA[p]   = $urandom_range(0, 12);
      end
      runSeq($urandom_range(0, 1) == 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
